// File: rtl/axis_write_burst_pkg.sv
// Shared definitions for the AXI write-burst address generator:
// FSM state encodings and AXI response constants.
package axis_write_burst_pkg;

  typedef enum logic [1:0] {
    CONFIG = 2'd0,
    DATA   = 2'd1,
    ADDR   = 2'd2,
    DRAIN  = 2'd3
  } state_t;

  localparam logic [1:0] BRESP_OKAY = 2'b00;

endpackage

// File: rtl/axis_write_burst_if.sv
// Request, data-channel configuration and AXI AW/B signals of the write-burst block.
// master is the burst generator side, slave is the requester/AXI-slave side.
interface axis_write_burst_if #(
  parameter int CFG_DWIDTH     = 32,
  parameter int AXI_ADDR_WIDTH = 32,
  parameter int AXI_LEN_WIDTH  = 8
);

  logic [AXI_ADDR_WIDTH-1:0] cfg_address;
  logic [CFG_DWIDTH-1:0]     cfg_length;
  logic                      cfg_val;
  logic                      cfg_rdy;

  logic [CFG_DWIDTH-1:0]     data_cfg_length;
  logic                      data_cfg_val;
  logic                      data_cfg_rdy;

  logic [AXI_ADDR_WIDTH-1:0] axi_awaddr;
  logic [AXI_LEN_WIDTH-1:0]  axi_awlen;
  logic                      axi_awvalid;
  logic                      axi_awready;

  logic [1:0]                axi_bresp;
  logic                      axi_bvalid;
  logic                      axi_bready;

  modport master (
    input  cfg_address, cfg_length, cfg_val,
    output cfg_rdy,
    output data_cfg_length, data_cfg_val,
    input  data_cfg_rdy,
    output axi_awaddr, axi_awlen, axi_awvalid,
    input  axi_awready,
    input  axi_bresp, axi_bvalid,
    output axi_bready
  );

  modport slave (
    output cfg_address, cfg_length, cfg_val,
    input  cfg_rdy,
    input  data_cfg_length, data_cfg_val,
    output data_cfg_rdy,
    input  axi_awaddr, axi_awlen, axi_awvalid,
    output axi_awready,
    output axi_bresp, axi_bvalid,
    input  axi_bready
  );

endinterface

// File: rtl/axis_write_burst_outstanding.sv
// Counter of AW bursts still waiting for their B response.
// Saturates at both ends; a simultaneous inc and dec leaves it unchanged.
module axis_outstanding_cnt #(
  parameter int MAX_OUTSTANDING = 8,
  parameter int CNT_W           = $clog2(MAX_OUTSTANDING + 1)
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             inc,
  input  logic             dec,
  output logic [CNT_W-1:0] count,
  output logic             full,
  output logic             empty
);

  assign full  = (count == CNT_W'(MAX_OUTSTANDING));
  assign empty = (count == '0);

  always_ff @(posedge clk) begin
    if (rst) begin
      count <= '0;
    end else if (inc && !dec && !full) begin
      count <= count + CNT_W'(1);
    end else if (dec && !inc && !empty) begin
      count <= count - CNT_W'(1);
    end
  end

endmodule

// File: rtl/axis_write_burst.sv
// Splits a stream-word write request into AXI AW bursts of at most 2^AXI_LEN_WIDTH beats,
// hands the length to the write-data block and waits for all B responses.
module axis_write_burst
  import axis_write_burst_pkg::*;
#(
  parameter int CFG_DWIDTH      = 32,
  parameter int AXI_ADDR_WIDTH  = 32,
  parameter int AXI_LEN_WIDTH   = 8,
  parameter int CONVERT_SHIFT   = 3,
  parameter int RATIO_SHIFT     = 1,
  parameter int MAX_OUTSTANDING = 8
) (
  input  logic                clk,
  input  logic                rst,
  axis_write_burst_if.master  bus,
  output logic                busy,
  output logic                done,
  output logic                error
);

  localparam int CNT_W = $clog2(MAX_OUTSTANDING + 1);
  localparam logic [CFG_DWIDTH-1:0] MAX_BURST = CFG_DWIDTH'(1) << AXI_LEN_WIDTH;

  state_t                    state, state_nxt;
  logic [AXI_ADDR_WIDTH-1:0] addr_q;
  logic [CFG_DWIDTH-1:0]     remaining, length_q, beats, burst_beats;
  logic                      err_q, zero_done_q;
  logic                      cfg_fire, aw_issue, aw_fire, b_fire, drain_exit;
  logic                      cnt_full, cnt_empty;
  logic [CNT_W-1:0]          outstanding;

  assign beats       = bus.cfg_length >> RATIO_SHIFT;
  assign burst_beats = (remaining >= MAX_BURST) ? MAX_BURST : remaining;

  assign cfg_fire   = bus.cfg_val & bus.cfg_rdy;
  assign aw_issue   = (state == ADDR) & ~cnt_full & ~rst;
  assign aw_fire    = aw_issue & bus.axi_awready;
  assign b_fire     = bus.axi_bvalid & ~rst;
  // Leave DRAIN only when nothing is in flight and no B is landing this very cycle
  assign drain_exit = (state == DRAIN) & (outstanding == '0) & ~b_fire & ~rst;

  assign bus.axi_awvalid     = aw_issue;
  assign bus.axi_awaddr      = addr_q;
  assign bus.axi_awlen       = AXI_LEN_WIDTH'(burst_beats - CFG_DWIDTH'(1));
  assign bus.axi_bready      = ~rst;
  assign bus.data_cfg_length = length_q;

  assign done  = (drain_exit | zero_done_q) & ~rst;
  assign error = err_q & ~rst;

  always_ff @(posedge clk) begin
    if (rst) state <= CONFIG;
    else     state <= state_nxt;
  end

  always_comb begin
    state_nxt        = state;
    bus.cfg_rdy      = 1'b0;
    bus.data_cfg_val = 1'b0;
    busy             = 1'b0;
    if (!rst) begin
      case (state)
        CONFIG: begin
          bus.cfg_rdy = 1'b1;
          if (bus.cfg_val && beats != '0) state_nxt = DATA;
        end
        DATA: begin
          busy             = 1'b1;
          bus.data_cfg_val = 1'b1;
          if (bus.data_cfg_rdy) state_nxt = ADDR;
        end
        ADDR: begin
          busy = 1'b1;
          if (aw_fire && remaining == burst_beats) state_nxt = DRAIN;
        end
        DRAIN: begin
          busy = 1'b1;
          if (drain_exit) state_nxt = CONFIG;
        end
        default: state_nxt = CONFIG;
      endcase
    end
  end

  // Request latch, burst address/length bookkeeping and sticky error
  always_ff @(posedge clk) begin
    if (rst) begin
      addr_q      <= '0;
      remaining   <= '0;
      length_q    <= '0;
      err_q       <= 1'b0;
      zero_done_q <= 1'b0;
    end else begin
      zero_done_q <= cfg_fire && (beats == '0);
      if (cfg_fire) begin
        addr_q    <= bus.cfg_address;
        remaining <= beats;
        length_q  <= bus.cfg_length;
      end else if (aw_fire) begin
        addr_q    <= addr_q + (AXI_ADDR_WIDTH'(burst_beats) << CONVERT_SHIFT);
        remaining <= remaining - burst_beats;
      end
      if (b_fire && bus.axi_bresp != BRESP_OKAY) err_q <= 1'b1;
      else if (cfg_fire)                         err_q <= 1'b0;
    end
  end

  axis_outstanding_cnt #(
    .MAX_OUTSTANDING (MAX_OUTSTANDING),
    .CNT_W           (CNT_W)
  ) u_cnt (
    .clk   (clk),
    .rst   (rst),
    .inc   (aw_fire),
    .dec   (b_fire & ~cnt_empty),
    .count (outstanding),
    .full  (cnt_full),
    .empty (cnt_empty)
  );

endmodule

// File: tb/tb_axis_write_burst.sv
// Directed bench for axis_write_burst: AW logging, a B responder with a
// fixed 4-cycle latency and hand-computed expected bursts.
module tb_axis_write_burst;

  logic clk = 1'b0;
  logic rst;
  logic busy, done, error;

  always #5 clk = ~clk;

  axis_write_burst_if #(.CFG_DWIDTH(32), .AXI_ADDR_WIDTH(32), .AXI_LEN_WIDTH(8)) bus ();

  axis_write_burst #(
    .CFG_DWIDTH(32), .AXI_ADDR_WIDTH(32), .AXI_LEN_WIDTH(8),
    .CONVERT_SHIFT(3), .RATIO_SHIFT(1), .MAX_OUTSTANDING(8)
  ) dut (
    .clk   (clk),
    .rst   (rst),
    .bus   (bus),
    .busy  (busy),
    .done  (done),
    .error (error)
  );

  int checks = 0;
  int errors = 0;
  int cycle_cnt = 0;

  logic [31:0] aw_addr_q[$];
  int          aw_len_q[$];
  int          b_due[$];
  int          b_allow;
  logic [1:0]  bresp_val;
  int          model_out, model_max;
  int          done_count, done_cycle, last_b_cycle, accept_cycle;
  logic        accepted, seen_data_val, seen_awvalid, last_awvalid, last_aw_hs, last_b_hs;
  logic [31:0] data_len_seen;

  task automatic checkOutput(input string tag, input logic [63:0] actual, input logic [63:0] expected);
    checks++;
    if (actual !== expected) begin
      errors++;
      $display("[TB] FAIL %s: got 0x%0h expected 0x%0h", tag, actual, expected);
    end
  endtask

  task automatic drive_b();
    bus.axi_bvalid = (b_allow > 0) && (b_due.size() > 0) && (b_due[0] <= cycle_cnt);
    bus.axi_bresp  = bus.axi_bvalid ? bresp_val : 2'b00;
  endtask

  // Sample one cycle just after the negedge, then advance to the next negedge
  task automatic tick();
    #1;
    last_aw_hs   = bus.axi_awvalid && bus.axi_awready;
    last_b_hs    = bus.axi_bvalid && bus.axi_bready;
    last_awvalid = bus.axi_awvalid;
    if (last_aw_hs) begin
      aw_addr_q.push_back(bus.axi_awaddr);
      aw_len_q.push_back(int'(bus.axi_awlen));
      b_due.push_back(cycle_cnt + 4);
      model_out++;
      if (model_out > model_max) model_max = model_out;
    end
    if (last_b_hs) begin
      void'(b_due.pop_front());
      model_out--;
      if (b_allow > 0) b_allow--;
      last_b_cycle = cycle_cnt;
    end
    if (bus.cfg_val && bus.cfg_rdy) begin
      accepted     = 1'b1;
      accept_cycle = cycle_cnt;
    end
    if (bus.data_cfg_val) begin
      seen_data_val = 1'b1;
      data_len_seen = bus.data_cfg_length;
    end
    if (bus.axi_awvalid) seen_awvalid = 1'b1;
    if (done) begin
      done_count++;
      done_cycle = cycle_cnt;
    end
    @(negedge clk);
    cycle_cnt++;
    drive_b();
  endtask

  task automatic clear_log();
    aw_addr_q.delete();
    aw_len_q.delete();
    model_max     = 0;
    done_count    = 0;
    seen_data_val = 1'b0;
    seen_awvalid  = 1'b0;
    data_len_seen = '0;
  endtask

  task automatic applyStimulus(input logic [31:0] addr, input logic [31:0] len);
    accepted        = 1'b0;
    bus.cfg_address = addr;
    bus.cfg_length  = len;
    bus.cfg_val     = 1'b1;
    for (int i = 0; i < 20 && !accepted; i++) tick();
    bus.cfg_val = 1'b0;
    checkOutput("cfg_accept", 64'(accepted), 64'd1);
  endtask

  task automatic waitDone(input int budget);
    for (int i = 0; i < budget && done_count == 0; i++) tick();
    checkOutput("done_seen", 64'(done_count != 0), 64'd1);
  endtask

  initial begin
    rst              = 1'b1;
    bus.cfg_address  = '0;
    bus.cfg_length   = '0;
    bus.cfg_val      = 1'b0;
    bus.data_cfg_rdy = 1'b1;
    bus.axi_awready  = 1'b1;
    bus.axi_bvalid   = 1'b0;
    bus.axi_bresp    = 2'b00;
    b_allow          = 1000000;
    bresp_val        = 2'b00;
    model_out        = 0;
    last_b_cycle     = -1;
    done_cycle       = -1;
    accept_cycle     = -1;
    clear_log();
    @(negedge clk);

    // Reset state
    tick();
    tick();
    #1;
    checkOutput("rst_cfg_rdy", 64'(bus.cfg_rdy), 64'd0);
    checkOutput("rst_bready", 64'(bus.axi_bready), 64'd0);
    checkOutput("rst_busy_done_err", {61'd0, busy, done, error}, 64'd0);
    checkOutput("rst_awvalid", 64'(bus.axi_awvalid), 64'd0);
    rst = 1'b0;
    tick();
    #1;
    checkOutput("idle_cfg_rdy", 64'(bus.cfg_rdy), 64'd1);
    checkOutput("idle_bready", 64'(bus.axi_bready), 64'd1);
    checkOutput("idle_busy", 64'(busy), 64'd0);

    // 1024 words -> two full 256-beat bursts
    clear_log();
    applyStimulus(32'h1000, 32'd1024);
    waitDone(500);
    tick(); tick(); tick();
    checkOutput("t1_aw_count", 64'(aw_addr_q.size()), 64'd2);
    checkOutput("t1_aw0_addr", 64'(aw_addr_q[0]), 64'h1000);
    checkOutput("t1_aw0_len", 64'(aw_len_q[0]), 64'd255);
    checkOutput("t1_aw1_addr", 64'(aw_addr_q[1]), 64'h1800);
    checkOutput("t1_aw1_len", 64'(aw_len_q[1]), 64'd255);
    checkOutput("t1_data_len", 64'(data_len_seen), 64'd1024);
    checkOutput("t1_done_latency", 64'(done_cycle - last_b_cycle), 64'd1);
    checkOutput("t1_done_pulses", 64'(done_count), 64'd1);
    checkOutput("t1_busy_after", 64'(busy), 64'd0);

    // 600 words -> 300 beats: 256 + 44
    clear_log();
    applyStimulus(32'h2000, 32'd600);
    waitDone(500);
    checkOutput("t2_aw_count", 64'(aw_addr_q.size()), 64'd2);
    checkOutput("t2_aw0_len", 64'(aw_len_q[0]), 64'd255);
    checkOutput("t2_aw1_addr", 64'(aw_addr_q[1]), 64'h2800);
    checkOutput("t2_aw1_len", 64'(aw_len_q[1]), 64'd43);

    // B withheld: 16 bursts, only 8 may be outstanding
    clear_log();
    b_allow = 0;
    applyStimulus(32'h0, 32'd8192);
    for (int i = 0; i < 30; i++) tick();
    checkOutput("t3_aw_capped", 64'(aw_addr_q.size()), 64'd8);
    checkOutput("t3_awvalid_low", 64'(last_awvalid), 64'd0);
    checkOutput("t3_max_out", 64'(model_max), 64'd8);
    b_allow = 1;
    drive_b();
    for (int i = 0; i < 20 && b_allow > 0; i++) tick();
    for (int i = 0; i < 10; i++) tick();
    checkOutput("t3_one_more_aw", 64'(aw_addr_q.size()), 64'd9);
    b_allow = 1000000;
    drive_b();
    waitDone(2000);
    checkOutput("t3_aw_total", 64'(aw_addr_q.size()), 64'd16);
    checkOutput("t3_last_addr", 64'(aw_addr_q[15]), 64'h7800);
    checkOutput("t3_max_out_final", 64'(model_max), 64'd8);

    // Simultaneous AW and B with 3 outstanding
    clear_log();
    b_allow = 0;
    bus.axi_awready = 1'b1;
    applyStimulus(32'h8000, 32'd4096);
    for (int i = 0; i < 50 && aw_addr_q.size() < 3; i++) tick();
    bus.axi_awready = 1'b0;
    tick(); tick();
    checkOutput("t4_out_before", 64'(dut.u_cnt.count), 64'd3);
    bus.axi_awready = 1'b1;
    b_allow = 1;
    drive_b();
    tick();
    bus.axi_awready = 1'b0;
    checkOutput("t4_both_hs", {62'd0, last_aw_hs, last_b_hs}, 64'd3);
    #1;
    checkOutput("t4_out_after", 64'(dut.u_cnt.count), 64'd3);
    bus.axi_awready = 1'b1;
    b_allow = 1000000;
    drive_b();
    waitDone(2000);
    checkOutput("t4_aw_total", 64'(aw_addr_q.size()), 64'd8);

    // Zero length: nothing issued, done the cycle after accept
    clear_log();
    applyStimulus(32'h3000, 32'd0);
    for (int i = 0; i < 5; i++) tick();
    checkOutput("t5_no_data_val", 64'(seen_data_val), 64'd0);
    checkOutput("t5_no_awvalid", 64'(seen_awvalid), 64'd0);
    checkOutput("t5_done_pulses", 64'(done_count), 64'd1);
    checkOutput("t5_done_latency", 64'(done_cycle - accept_cycle), 64'd1);

    // SLVERR response makes error sticky until the next accept
    clear_log();
    bresp_val = 2'b10;
    applyStimulus(32'h4000, 32'd512);
    waitDone(500);
    bresp_val = 2'b00;
    tick(); tick(); tick();
    #1;
    checkOutput("t6_error_set", 64'(error), 64'd1);
    applyStimulus(32'h5000, 32'd0);
    #1;
    checkOutput("t6_error_cleared", 64'(error), 64'd0);
    tick(); tick();

    // Reset while AW is pending
    clear_log();
    bus.axi_awready = 1'b0;
    applyStimulus(32'h6000, 32'd512);
    for (int i = 0; i < 10 && !last_awvalid; i++) tick();
    checkOutput("t7_awvalid_pending", 64'(last_awvalid), 64'd1);
    rst = 1'b1;
    tick();
    checkOutput("t7_awvalid_in_rst", 64'(last_awvalid), 64'd0);
    rst = 1'b0;
    tick();
    #1;
    checkOutput("t7_awvalid_after", 64'(bus.axi_awvalid), 64'd0);
    checkOutput("t7_cfg_rdy", 64'(bus.cfg_rdy), 64'd1);
    checkOutput("t7_busy", 64'(busy), 64'd0);
    for (int i = 0; i < 5; i++) tick();
    checkOutput("t7_no_done", 64'(done_count), 64'd0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
